aes256_mixcolumns_iter: RTL

Sequential MixColumns/InvMixColumns engine for the AES-256 round datapath; the parametrised successor to the combinational aes256_mixcolumns.
Processes COLS_PER_CYCLE columns per clock, trading area against latency.
Uses a valid/ready handshake on both sides, latches mode per transaction and has a bypass for the final round.
Sits between ShiftRows and AddRoundKey in the iterative round controller.

---
 rtl/aes256_mixcolumns_iter_pkg.sv | 21 ++
 rtl/aes256_mixcolumn_col.sv | 35 +++
 rtl/aes256_mixcolumns_iter.sv | 107 ++++++++++
 3 files changed

// File: rtl/aes256_mixcolumns_iter_pkg.sv
// Shared constants for the iterative MixColumns engine: mode codes, FSM encoding
// and the GF(2^8) doubling helper.
package aes256_mixcolumns_iter_pkg;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Reduction term of x^8 modulo x^8 + x^4 + x^3 + x + 1
  localparam logic [7:0] GF_RED = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_RED : 8'h00);
  endfunction

endpackage

// File: rtl/aes256_mixcolumn_col.sv
// Combinational single-column MixColumns / InvMixColumns built from xtime chains.
module aes256_mixcolumn_col
  import aes256_mixcolumns_iter_pkg::*;
(
  input  logic        mode_i,
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a  [4];
  logic [7:0] m2 [4];
  logic [7:0] m4 [4];
  logic [7:0] m8 [4];

  always_comb begin
    col_o = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col_i[31-8*i -: 8];
      m2[i] = xtime(a[i]);
      m4[i] = xtime(m2[i]);
      m8[i] = xtime(m4[i]);
    end
    // 0E = 8^4^2, 0B = 8^2^1, 0D = 8^4^1, 09 = 8^1
    for (int i = 0; i < 4; i++) begin
      if (mode_i == MODE_ENC)
        col_o[31-8*i -: 8] = m2[i] ^ m2[(i+1)%4] ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
      else
        col_o[31-8*i -: 8] = (m8[i] ^ m4[i] ^ m2[i])
                           ^ (m8[(i+1)%4] ^ m2[(i+1)%4] ^ a[(i+1)%4])
                           ^ (m8[(i+2)%4] ^ m4[(i+2)%4] ^ a[(i+2)%4])
                           ^ (m8[(i+3)%4] ^ a[(i+3)%4]);
    end
  end

endmodule

// File: rtl/aes256_mixcolumns_iter.sv
// Iterative MixColumns/InvMixColumns engine, COLS_PER_CYCLE columns per beat,
// valid/ready on both sides, per-transaction mode latch and last-round bypass.
//   state   | meaning
//   ST_IDLE | empty, ready for a new state
//   ST_RUN  | transforming columns, one beat per clock
//   ST_DONE | result held on state_o until downstream takes it
module aes256_mixcolumns_iter
  import aes256_mixcolumns_iter_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         mode_i,
  input  logic         bypass_i,
  input  logic [127:0] state_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] state_o,
  output logic         busy_o
);

  localparam int NUM_BEATS = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_BEAT = 2'(NUM_BEATS - 1);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  state_e                      state_q;
  logic [1:0]                  cnt_q;
  logic [127:0]                data_q;
  logic [127:0]                data_d;
  logic                        mode_q;
  logic                        valid_q;
  logic [32*COLS_PER_CYCLE-1:0] lane_out;
  logic                        accept;

  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
    logic [31:0] col_in;
    always_comb begin
      col_in = '0;
      for (int b = 0; b < NUM_BEATS; b++)
        if (cnt_q == 2'(b)) col_in = data_q[127-32*(b*COLS_PER_CYCLE+j) -: 32];
    end
    aes256_mixcolumn_col u_col (
      .mode_i(mode_q),
      .col_i (col_in),
      .col_o (lane_out[32*j +: 32])
    );
  end

  // Column g belongs to beat g/C and is computed by lane g%C.
  for (genvar g = 0; g < 4; g++) begin : g_col
    localparam int         LANE = g % COLS_PER_CYCLE;
    localparam logic [1:0] BEAT = 2'(g / COLS_PER_CYCLE);
    assign data_d[127-32*g -: 32] = (cnt_q == BEAT) ? lane_out[32*LANE +: 32]
                                                    : data_q[127-32*g -: 32];
  end

  assign ready_o = !rst_i && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && ready_i));
  assign accept  = valid_i && ready_o;
  assign valid_o = valid_q;
  assign state_o = data_q;
  assign busy_o  = (state_q != ST_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      mode_q  <= MODE_ENC;
      valid_q <= 1'b0;
    end else if (accept) begin
      data_q  <= state_i;
      mode_q  <= mode_i;
      cnt_q   <= '0;
      state_q <= bypass_i ? ST_DONE : ST_RUN;
      valid_q <= bypass_i;
    end else begin
      case (state_q)
        ST_RUN: begin
          data_q <= data_d;
          cnt_q  <= cnt_q + 2'd1;
          if (cnt_q == LAST_BEAT) begin
            state_q <= ST_DONE;
            valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (ready_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        ST_IDLE: ;
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
